bus_xfer_seq: RTL



---
 rtl/bus_xfer_seq_pkg.sv | 28 ++
 rtl/bus_xfer_seq_if.sv | 26 ++
 rtl/bus_xfer_seq_dec.sv | 22 ++
 rtl/bus_xfer_seq.sv | 106 ++++++++++
 4 files changed

// File: rtl/bus_xfer_seq_pkg.sv
// Shared definitions for the bus transfer sequencer: register codes, code-space
// sizes and the sequencer state encoding.
package bus_xfer_seq_pkg;

  localparam int unsigned NUM_SRC = 24;
  localparam int unsigned NUM_DST = 26;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned IN_W    = 32;

  typedef enum logic [CODE_W-1:0] {
    SRC_R[16], SRC_HI, SRC_LO, SRC_ZHIGH, SRC_ZLOW,
    SRC_PC, SRC_MDR, SRC_INPORT, SRC_C
  } src_code_e;

  typedef enum logic [CODE_W-1:0] {
    DST_R[16], DST_HI, DST_LO, DST_Z, DST_Y, DST_PC,
    DST_MDR, DST_MAR, DST_IR, DST_OUTPORT, DST_CON
  } dst_code_e;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    LATCH,
    FIN,
    ERR
  } state_e;

endpackage

// File: rtl/bus_xfer_seq_if.sv
// Request/strobe bundle between the control unit (master) and the transfer
// sequencer (slave).
interface bus_xfer_seq_if;
  import bus_xfer_seq_pkg::*;

  logic                req_valid;
  logic [CODE_W-1:0]   req_src;
  logic [CODE_W-1:0]   req_dst;
  logic                req_ready;
  logic [NUM_SRC-1:0]  out_strobe;
  logic [IN_W-1:0]     in_strobe;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, out_strobe, in_strobe, busy, done, err
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, out_strobe, in_strobe, busy, done, err
  );

endinterface

// File: rtl/bus_xfer_seq_dec.sv
// 5-to-N one-hot decoder; codes at or above N decode to all-zero and drop the
// legal flag.
module xfer_onehot_dec #(
  parameter int unsigned N = 24
) (
  input  logic [4:0]   code,
  output logic [N-1:0] onehot,
  output logic         legal
);

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves a bit unassigned and no latch is inferred.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < int'(N); i++) begin
      onehot[i] = (code == 5'(i));
    end
  end

  assign legal = ({27'b0, code} < N);

endmodule

// File: rtl/bus_xfer_seq.sv
// Drive-side bus transfer sequencer: decodes a source/destination pair and
// walks the out/in strobes through DRIVE -> LATCH -> FIN.
module bus_xfer_seq
  import bus_xfer_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic clock,
  input  logic clear,
  bus_xfer_seq_if.slave bus
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_e              state, state_nxt;
  logic [3:0]          settle_cnt, settle_cnt_nxt;
  logic [NUM_SRC-1:0]  src_oh, src_oh_q, out_strobe_nxt;
  logic [NUM_DST-1:0]  dst_oh, dst_oh_q;
  logic [IN_W-1:0]     in_strobe_nxt;
  logic                src_legal, dst_legal;
  logic                busy_nxt, done_nxt, err_nxt;
  logic                accept;

  xfer_onehot_dec #(.N(NUM_SRC)) u_src_dec (
    .code   (bus.req_src),
    .onehot (src_oh),
    .legal  (src_legal)
  );

  xfer_onehot_dec #(.N(NUM_DST)) u_dst_dec (
    .code   (bus.req_dst),
    .onehot (dst_oh),
    .legal  (dst_legal)
  );

  assign bus.req_ready = (state == IDLE);
  assign accept        = (state == IDLE) && (state_nxt == DRIVE);

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (src_legal && dst_legal) begin
            state_nxt      = DRIVE;
            settle_cnt_nxt = SETTLE_INIT;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      DRIVE: begin
        if (settle_cnt == 4'd0) state_nxt = LATCH;
        else                    settle_cnt_nxt = settle_cnt - 4'd1;
      end
      LATCH:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it; on
  // the accept edge the source comes straight from the decoder.
  always_comb begin
    busy_nxt       = (state_nxt == DRIVE) || (state_nxt == LATCH);
    done_nxt       = (state_nxt == FIN);
    err_nxt        = (state_nxt == ERR);
    out_strobe_nxt = '0;
    in_strobe_nxt  = '0;
    if (busy_nxt) out_strobe_nxt = (state == IDLE) ? src_oh : src_oh_q;
    if (state_nxt == LATCH) in_strobe_nxt = IN_W'(dst_oh_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!clear) begin
      // NOTE: the latched one-hot vectors are cleared with the control state
      // so a reset can never release a stale strobe pattern.
      state          <= IDLE;
      settle_cnt     <= '0;
      src_oh_q       <= '0;
      dst_oh_q       <= '0;
      bus.out_strobe <= '0;
      bus.in_strobe  <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      state          <= state_nxt;
      settle_cnt     <= settle_cnt_nxt;
      bus.out_strobe <= out_strobe_nxt;
      bus.in_strobe  <= in_strobe_nxt;
      bus.busy       <= busy_nxt;
      bus.done       <= done_nxt;
      bus.err        <= err_nxt;
      if (accept) begin
        src_oh_q <= src_oh;
        dst_oh_q <= dst_oh;
      end
    end
  end

endmodule
